instruction_fetch: RTL and testbench

Fetch stage of the single-cycle/pipelined MIPS core. It owns the program counter and drives the address of the combinational instruction memory. It captures the returned word into an IF/ID output register with a valid flag, for the decode stage downstream. It supports stall, branch/jump redirect with flush, and a sticky halt on a misaligned redirect target.

---
 rtl/mips_pkg.sv | 18 +
 rtl/pc_next_sel.sv | 29 ++
 rtl/instruction_fetch.sv | 124 ++++++++++++
 tb/tb_instruction_fetch.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch stage.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] PC_STEP = 32'd4;
  localparam logic [WORD_W-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } fetch_state_t;

  function automatic logic is_word_aligned(input logic [WORD_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection for the fetch stage: redirect > stall > sequential advance.
// A misaligned redirect keeps the current PC and raises misalign.
module pc_next_sel
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] pc,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_target,
  output logic [WORD_W-1:0] pc_next,
  output logic              misalign
);

  always_comb begin
    pc_next  = pc + PC_STEP;
    misalign = 1'b0;
    if (redirect_valid) begin
      if (is_word_aligned(redirect_target)) begin
        pc_next = redirect_target;
      end else begin
        pc_next  = pc;
        misalign = 1'b1;
      end
    end else if (stall) begin
      pc_next = pc;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: PC, IF/ID register, BOOT/RUN/HALT control.
// Optional fetch_count output when FETCH_PERF_CNT_EN is defined.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [WORD_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_target,
  output logic [WORD_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_instr,
  output logic              if_valid,
  output logic [WORD_W-1:0] if_instr,
  output logic [WORD_W-1:0] if_pc,
  output logic [WORD_W-1:0] if_pc_plus4,
  output logic              misalign_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [WORD_W-1:0] fetch_count
`endif
);

  fetch_state_t      state_reg, state_next;
  logic [WORD_W-1:0] pc_reg, pc_next;
  logic              valid_reg, valid_next;
  logic [WORD_W-1:0] instr_reg, instr_next;
  logic [WORD_W-1:0] ifpc_reg, ifpc_next;
  logic [WORD_W-1:0] ifpc4_reg, ifpc4_next;
  logic              misalign_reg, misalign_next;
  logic [WORD_W-1:0] sel_pc;
  logic              sel_misalign;

  pc_next_sel u_pc_next_sel (
    .pc              (pc_reg),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pc_next         (sel_pc),
    .misalign        (sel_misalign)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= BOOT;
      pc_reg       <= RESET_PC;
      valid_reg    <= 1'b0;
      instr_reg    <= NOP_WORD;
      ifpc_reg     <= '0;
      ifpc4_reg    <= '0;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      valid_reg    <= valid_next;
      instr_reg    <= instr_next;
      ifpc_reg     <= ifpc_next;
      ifpc4_reg    <= ifpc4_next;
      misalign_reg <= misalign_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    valid_next    = valid_reg;
    instr_next    = instr_reg;
    ifpc_next     = ifpc_reg;
    ifpc4_next    = ifpc4_reg;
    misalign_next = misalign_reg;
    case (state_reg)
      HALT: begin
        // Frozen until reset; the slot was already flushed on entry.
      end
      default: begin
        if (redirect_valid) begin
          pc_next    = sel_pc;
          valid_next = 1'b0;
          instr_next = NOP_WORD;
          if (sel_misalign) begin
            misalign_next = 1'b1;
            state_next    = HALT;
          end else begin
            state_next = RUN;
          end
        end else if (state_reg == BOOT) begin
          state_next = RUN;
        end else if (!stall) begin
          pc_next    = sel_pc;
          valid_next = 1'b1;
          instr_next = imem_instr;
          ifpc_next  = pc_reg;
          ifpc4_next = pc_reg + PC_STEP;
        end
      end
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  logic [WORD_W-1:0] count_reg;

  // Counts only cycles that load a real instruction into the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (state_reg == RUN && !redirect_valid && !stall) begin
      count_reg <= count_reg + 32'd1;
    end
  end

  assign fetch_count = count_reg;
`endif

  assign imem_addr    = pc_reg;
  assign if_valid     = valid_reg;
  assign if_instr     = instr_reg;
  assign if_pc        = ifpc_reg;
  assign if_pc_plus4  = ifpc4_reg;
  assign misalign_err = misalign_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table plus
// randomized cycles against a behavioural model.
module tb_instruction_fetch;

  localparam logic [31:0] SALT = 32'hA5A5_0000;
  localparam int RAND_CYCLES = 400;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr, imem_instr;
  logic        if_valid;
  logic [31:0] if_instr, if_pc, if_pc_plus4;
  logic        misalign_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  always #5 clk = ~clk;

  assign imem_instr = imem_addr ^ SALT;

  instruction_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_pc_plus4     (if_pc_plus4),
    .misalign_err    (misalign_err)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count     (fetch_count)
`endif
  );

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        rv;
    logic [31:0] tgt;
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] addr;
    logic        err;
  } vec_t;

  vec_t tbl [21];

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: the fetch stage described as a few plain variables.
  logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4, m_count;
  logic        m_valid, m_err, m_boot;

  task automatic model_step();
    if (rst) begin
      m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0;
      m_ifpc = 32'h0; m_ifpc4 = 32'h0; m_err = 1'b0;
      m_boot = 1'b1; m_count = 32'h0;
    end else if (m_err) begin
      // halted: nothing moves
    end else if (redirect_valid) begin
      m_valid = 1'b0;
      m_instr = 32'h0;
      m_boot  = 1'b0;
      if (redirect_target % 4 != 0) m_err = 1'b1;
      else m_pc = redirect_target;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (!stall) begin
      m_instr = m_pc ^ SALT;
      m_ifpc  = m_pc;
      m_ifpc4 = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
      m_count = m_count + 32'd1;
    end
  endtask

  task automatic check(input string tag, input logic e_v, input logic [31:0] e_instr,
                       input logic [31:0] e_pc, input logic [31:0] e_pc4,
                       input logic [31:0] e_addr, input logic e_err);
    logic bad;
    bad = 1'b0;
    vectors++;
    if (if_valid !== e_v || if_instr !== e_instr || if_pc !== e_pc ||
        if_pc_plus4 !== e_pc4 || imem_addr !== e_addr || misalign_err !== e_err)
      bad = 1'b1;
`ifdef FETCH_PERF_CNT_EN
    if (fetch_count !== m_count) begin
      bad = 1'b1;
      $display("FAIL %s fetch_count got %h want %h", tag, fetch_count, m_count);
    end
`endif
    if (bad) begin
      miscompares++;
      $display("FAIL %s got v=%b instr=%h pc=%h pc4=%h addr=%h err=%b want v=%b instr=%h pc=%h pc4=%h addr=%h err=%b",
               tag, if_valid, if_instr, if_pc, if_pc_plus4, imem_addr, misalign_err,
               e_v, e_instr, e_pc, e_pc4, e_addr, e_err);
    end else begin
      $display("vec %0d %s ok addr=%h if_pc=%h v=%b", vectors, tag, imem_addr, if_pc, if_valid);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic rv, input logic [31:0] t,
                              input logic v, input logic [31:0] ins, input logic [31:0] p,
                              input logic [31:0] p4, input logic [31:0] a, input logic e);
    vec_t x;
    x = '{rst: r, stall: s, rv: rv, tgt: t, v: v, instr: ins, pc: p, pc4: p4, addr: a, err: e};
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    logic [31:0] t;
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    m_pc = 0; m_instr = 0; m_ifpc = 0; m_ifpc4 = 0; m_count = 0;
    m_valid = 0; m_err = 0; m_boot = 1;

    //            rst  stl  rv   target         v    instr          pc             pc4            addr           err
    tbl[0]  = mk(1'b1,1'b0,1'b0,32'h0,         1'b0,32'h0,         32'h0,         32'h0,         32'h0,         1'b0);
    tbl[1]  = mk(1'b1,1'b0,1'b0,32'h0,         1'b0,32'h0,         32'h0,         32'h0,         32'h0,         1'b0);
    tbl[2]  = mk(1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,         32'h0,         32'h0,         32'h0,         1'b0);
    tbl[3]  = mk(1'b0,1'b0,1'b0,32'h0,         1'b1,32'hA5A5_0000, 32'h0,         32'h4,         32'h4,         1'b0);
    tbl[4]  = mk(1'b0,1'b0,1'b0,32'h0,         1'b1,32'hA5A5_0004, 32'h4,         32'h8,         32'h8,         1'b0);
    tbl[5]  = mk(1'b0,1'b1,1'b0,32'h0,         1'b1,32'hA5A5_0004, 32'h4,         32'h8,         32'h8,         1'b0);
    tbl[6]  = mk(1'b0,1'b1,1'b0,32'h0,         1'b1,32'hA5A5_0004, 32'h4,         32'h8,         32'h8,         1'b0);
    tbl[7]  = mk(1'b0,1'b1,1'b0,32'h0,         1'b1,32'hA5A5_0004, 32'h4,         32'h8,         32'h8,         1'b0);
    tbl[8]  = mk(1'b0,1'b0,1'b0,32'h0,         1'b1,32'hA5A5_0008, 32'h8,         32'hC,         32'hC,         1'b0);
    tbl[9]  = mk(1'b0,1'b1,1'b1,32'h0000_0100, 1'b0,32'h0,         32'h8,         32'hC,         32'h100,       1'b0);
    tbl[10] = mk(1'b0,1'b0,1'b0,32'h0,         1'b1,32'hA5A5_0100, 32'h100,       32'h104,       32'h104,       1'b0);
    tbl[11] = mk(1'b0,1'b0,1'b1,32'hFFFF_FFFC, 1'b0,32'h0,         32'h100,       32'h104,       32'hFFFF_FFFC, 1'b0);
    tbl[12] = mk(1'b0,1'b0,1'b0,32'h0,         1'b1,32'h5A5A_FFFC, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b0);
    tbl[13] = mk(1'b0,1'b0,1'b0,32'h0,         1'b1,32'hA5A5_0000, 32'h0,         32'h4,         32'h4,         1'b0);
    tbl[14] = mk(1'b0,1'b0,1'b1,32'h0000_0102, 1'b0,32'h0,         32'h0,         32'h4,         32'h4,         1'b1);
    tbl[15] = mk(1'b0,1'b0,1'b1,32'h0000_0200, 1'b0,32'h0,         32'h0,         32'h4,         32'h4,         1'b1);
    tbl[16] = mk(1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,         32'h0,         32'h4,         32'h4,         1'b1);
    tbl[17] = mk(1'b0,1'b1,1'b0,32'h0,         1'b0,32'h0,         32'h0,         32'h4,         32'h4,         1'b1);
    tbl[18] = mk(1'b1,1'b0,1'b0,32'h0,         1'b0,32'h0,         32'h0,         32'h0,         32'h0,         1'b0);
    tbl[19] = mk(1'b0,1'b0,1'b1,32'h0000_0040, 1'b0,32'h0,         32'h0,         32'h0,         32'h40,        1'b0);
    tbl[20] = mk(1'b0,1'b0,1'b0,32'h0,         1'b1,32'hA5A5_0040, 32'h40,        32'h44,        32'h44,        1'b0);

    @(negedge clk);
    for (int i = 0; i < 21; i++) begin
      rst = tbl[i].rst; stall = tbl[i].stall;
      redirect_valid = tbl[i].rv; redirect_target = tbl[i].tgt;
      step();
      check($sformatf("tbl%0d", i), tbl[i].v, tbl[i].instr, tbl[i].pc, tbl[i].pc4,
            tbl[i].addr, tbl[i].err);
    end

    // Randomized phase against the model, starting from a reset.
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    step();
    check("rnd_rst", m_valid, m_instr, m_ifpc, m_ifpc4, m_pc, m_err);
    for (int i = 0; i < RAND_CYCLES; i++) begin
      rst            = ($urandom_range(0, 31) == 0);
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      t = $urandom();
      if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
      if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
      redirect_target = t;
      step();
      check($sformatf("rnd%0d", i), m_valid, m_instr, m_ifpc, m_ifpc4, m_pc, m_err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
